seven_segment_scan_decoder: RTL and testbench

SEVEN_SEGMENT_SCAN_DECODER -- requirements
Module: seven_segment_scan_decoder

---
 rtl/seven_segment_pkg.sv | 40 ++++
 rtl/seven_segment_pattern_decoder.sv | 35 +++
 rtl/seven_segment_scan_decoder.sv | 157 +++++++++++++++
 tb/tb_seven_segment_scan_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low cathode
// patterns (bit6 = a ... bit0 = g), active-low anode selects and FSM states.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODE_ONES      = 4'b1110;
  localparam logic [3:0] ANODE_TENS      = 4'b1101;
  localparam logic [3:0] ANODE_HUNDREDS  = 4'b1011;
  localparam logic [3:0] ANODE_THOUSANDS = 4'b0111;
  localparam logic [3:0] ANODE_BLANK     = 4'b1111;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HELD
  } scan_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } seg_decode_t;

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational cathode-pattern to hex-nibble decoder; unknown patterns
// report valid = 0.
module seven_segment_pattern_decoder
  import seven_segment_pkg::*;
(
  input  logic [6:0]  pattern_i,
  output seg_decode_t decode_o
);

  // Look up the nibble for a lit pattern, flag anything not in the table.
  always_comb begin
    // NOTE: a default is assigned first so no path leaves decode_o unassigned (no latch).
    decode_o = '{valid: 1'b1, nibble: 4'h0};
    case (pattern_i)
      SEG_0:   decode_o.nibble = 4'h0;
      SEG_1:   decode_o.nibble = 4'h1;
      SEG_2:   decode_o.nibble = 4'h2;
      SEG_3:   decode_o.nibble = 4'h3;
      SEG_4:   decode_o.nibble = 4'h4;
      SEG_5:   decode_o.nibble = 4'h5;
      SEG_6:   decode_o.nibble = 4'h6;
      SEG_7:   decode_o.nibble = 4'h7;
      SEG_8:   decode_o.nibble = 4'h8;
      SEG_9:   decode_o.nibble = 4'h9;
      SEG_A:   decode_o.nibble = 4'hA;
      SEG_B:   decode_o.nibble = 4'hB;
      SEG_C:   decode_o.nibble = 4'hC;
      SEG_D:   decode_o.nibble = 4'hD;
      SEG_E:   decode_o.nibble = 4'hE;
      SEG_F:   decode_o.nibble = 4'hF;
      default: decode_o.valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Recovers the four hex digits shown on a multiplexed, active-low
// seven-segment display by watching its anode and cathode lines. A digit is
// captured once per stable window; a frame is published once all four
// positions have been seen.
module seven_segment_scan_decoder
  import seven_segment_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_100_Mhz,
  input  logic        reset,
  input  logic [3:0]  anode_bits,
  input  logic [6:0]  seven_segments_LED_output,
  output logic [15:0] HEX_display_digits,
  output logic [3:0]  LED_binary_coded_decimal,
  output logic        digit_valid,
  output logic        frame_valid,
  output logic        pattern_error,
  output logic        anode_error,
  output logic        scan_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  // The change is seen one edge after it is registered, so the window ends
  // when the count, cleared on that edge, reaches SETTLE_CYCLES-2.
  localparam logic [7:0]    SETTLE_LAST  = 8'(SETTLE_CYCLES - 2);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);

  logic [3:0]    anode_q;
  logic [6:0]    seg_q;
  logic [10:0]   prev_q;
  logic [7:0]    stable_cnt_q, stable_cnt_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;

  scan_state_e   state_q;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    seen_q, seen_d;
  logic [15:0]   hex_q;
  logic [3:0]    bcd_q;
  logic          digit_valid_q, frame_valid_q;
  logic          pattern_error_q, anode_error_q, scan_timeout_q;

  logic          changed, window_done;
  logic          slot_valid, multi_low;
  logic [1:0]    slot;
  logic          capture, reject_anode, reject_pattern, timeout_hit;
  seg_decode_t   decoded;

  seven_segment_pattern_decoder u_pattern_decoder (
    .pattern_i (seg_q),
    .decode_o  (decoded)
  );

  // Window bookkeeping, anode classification and the evaluation outcome.
  always_comb begin
    changed      = {anode_q, seg_q} != prev_q;
    stable_cnt_d = changed ? 8'd0
                 : (stable_cnt_q == 8'hFF ? stable_cnt_q : stable_cnt_q + 8'd1);
    window_done  = (state_q == ST_SETTLE) && !changed && (stable_cnt_q == SETTLE_LAST);

    slot_valid = 1'b1;
    slot       = 2'd0;
    case (anode_q)
      ANODE_ONES:      slot = 2'd0;
      ANODE_TENS:      slot = 2'd1;
      ANODE_HUNDREDS:  slot = 2'd2;
      ANODE_THOUSANDS: slot = 2'd3;
      default:         slot_valid = 1'b0;
    endcase
    multi_low = !slot_valid && (anode_q != ANODE_BLANK);

    capture        = window_done && slot_valid && decoded.valid;
    reject_anode   = window_done && multi_low;
    reject_pattern = window_done && slot_valid && !decoded.valid;

    shadow_d = shadow_q;
    shadow_d[{slot, 2'b00} +: 4] = decoded.nibble;
    seen_d   = seen_q | (4'b0001 << slot);

    timeout_hit   = timeout_cnt_q == TIMEOUT_LAST;
    timeout_cnt_d = capture ? '0
                  : (timeout_cnt_q == TIMEOUT_MAX ? timeout_cnt_q : timeout_cnt_q + TW'(1));
  end

  // Input registers plus the stable-window and timeout counters.
  always_ff @(posedge clk_100_Mhz) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      anode_q       <= ANODE_BLANK;
      seg_q         <= SEG_BLANK;
      prev_q        <= {ANODE_BLANK, SEG_BLANK};
      stable_cnt_q  <= '0;
      timeout_cnt_q <= '0;
    end else begin
      anode_q       <= anode_bits;
      seg_q         <= seven_segments_LED_output;
      prev_q        <= {anode_q, seg_q};
      stable_cnt_q  <= stable_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  // Scan FSM with the shadow, frame and all registered outputs.
  always_ff @(posedge clk_100_Mhz) begin
    if (reset) begin
      state_q         <= ST_WAIT;
      shadow_q        <= '0;
      seen_q          <= '0;
      hex_q           <= '0;
      bcd_q           <= '0;
      digit_valid_q   <= 1'b0;
      frame_valid_q   <= 1'b0;
      pattern_error_q <= 1'b0;
      anode_error_q   <= 1'b0;
      scan_timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT:   if (changed) state_q <= ST_SETTLE;
        ST_SETTLE: if (window_done) state_q <= ST_HELD;
        ST_HELD:   if (changed) state_q <= ST_SETTLE;
        default:   state_q <= ST_WAIT;
      endcase

      digit_valid_q   <= capture;
      frame_valid_q   <= capture && (seen_d == 4'hF);
      anode_error_q   <= reject_anode;
      pattern_error_q <= reject_pattern;

      if (capture) begin
        // A capture outranks a coincident timeout terminal count.
        shadow_q       <= shadow_d;
        bcd_q          <= decoded.nibble;
        scan_timeout_q <= 1'b0;
        if (seen_d == 4'hF) begin
          hex_q  <= shadow_d;
          seen_q <= '0;
        end else begin
          seen_q <= seen_d;
        end
      end else if (timeout_hit) begin
        scan_timeout_q <= 1'b1;
        seen_q         <= '0;
      end
    end
  end

  assign HEX_display_digits       = hex_q;
  assign LED_binary_coded_decimal = bcd_q;
  assign digit_valid              = digit_valid_q;
  assign frame_valid              = frame_valid_q;
  assign pattern_error            = pattern_error_q;
  assign anode_error              = anode_error_q;
  assign scan_timeout             = scan_timeout_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Scoreboard bench for seven_segment_scan_decoder: each stimulus step pushes
// the events it should cause (kind, value, edge number) and a negedge
// monitor pops and compares them as the DUT pulses.
module tb_seven_segment_scan_decoder;

  typedef enum int {EV_NONE, EV_DIGIT, EV_FRAME, EV_AERR, EV_PERR, EV_TSET, EV_TCLR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] value;
    int          cycle;
  } ev_t;

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk;
  logic        reset;
  logic [3:0]  anode_bits;
  logic [6:0]  segs;
  logic [15:0] hex;
  logic [3:0]  bcd;
  logic        dv, fv, pe, ae, tout;

  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_pass    = 0;
  bit   mon_en    = 1'b0;
  logic tout_prev = 1'b0;
  ev_t  sb_q[$];

  seven_segment_scan_decoder #(
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_100_Mhz               (clk),
    .reset                     (reset),
    .anode_bits                (anode_bits),
    .seven_segments_LED_output (segs),
    .HEX_display_digits        (hex),
    .LED_binary_coded_decimal  (bcd),
    .digit_valid               (dv),
    .frame_valid               (fv),
    .pattern_error             (pe),
    .anode_error               (ae),
    .scan_timeout              (tout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push(input ev_kind_e k, input logic [15:0] v, input int c);
    ev_t e;
    e.kind  = k;
    e.value = v;
    e.cycle = c;
    sb_q.push_back(e);
  endtask

  task automatic expect_event(input ev_kind_e k, input logic [15:0] v);
    ev_t e;
    if (sb_q.size() == 0) begin
      check($sformatf("unexpected_%s", k.name()), 64'(k), 64'(EV_NONE));
    end else begin
      e = sb_q.pop_front();
      check($sformatf("event_%s", e.kind.name()), {16'h0, 32'(k), v}, {16'h0, 32'(e.kind), e.value});
      check($sformatf("cycle_%s", e.kind.name()), 64'(cyc), 64'(e.cycle));
    end
  endtask

  // Monitor: every DUT event is matched against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dv) expect_event(EV_DIGIT, {12'h0, bcd});
      if (fv) expect_event(EV_FRAME, hex);
      if (ae) expect_event(EV_AERR, 16'h0);
      if (pe) expect_event(EV_PERR, 16'h0);
      if (tout && !tout_prev) expect_event(EV_TSET, 16'h0);
      if (!tout && tout_prev) expect_event(EV_TCLR, 16'h0);
    end
    tout_prev <= tout;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Apply a new scan value; e0 is the edge that registers it.
  task automatic start(input logic [3:0] an, input logic [6:0] sg, output int e0);
    anode_bits = an;
    segs       = sg;
    e0         = cyc + 1;
  endtask

  task automatic cap(input logic [3:0] an, input int d, input int hold,
                     input bit frame, input logic [15:0] fval);
    int e0;
    start(an, SEG[d], e0);
    push(EV_DIGIT, 16'(d), e0 + 4);
    if (frame) push(EV_FRAME, fval, e0 + 4);
    idle(hold);
  endtask

  initial begin
    int e0;
    reset      = 1'b1;
    anode_bits = 4'hF;
    segs       = 7'h7F;
    idle(3);
    check("reset_hex", 64'(hex), 64'h0);
    check("reset_bcd", 64'(bcd), 64'h0);
    check("reset_flags", 64'({dv, fv, pe, ae, tout}), 64'h0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Full frame thousands..ones; frame lands with the ones capture.
    cap(4'b0111, 1, 8, 1'b0, 16'h0);
    cap(4'b1011, 2, 8, 1'b0, 16'h0);
    cap(4'b1101, 3, 8, 1'b0, 16'h0);
    cap(4'b1110, 4, 8, 1'b1, 16'h1234);
    check("hex_1234", 64'(hex), 64'h1234);

    // Single digit held 20 cycles gives exactly one capture at edge+4.
    cap(4'b1110, 1, 20, 1'b0, 16'h0);
    check("bcd_one", 64'(bcd), 64'h1);

    // Short window, then a blank gap: neither evaluates to anything.
    start(4'b1101, SEG[5], e0);
    idle(3);
    start(4'b1111, 7'h7F, e0);
    idle(8);

    // Two anodes low, then an unknown pattern: one error pulse each.
    start(4'b1100, SEG[8], e0);
    push(EV_AERR, 16'h0, e0 + 4);
    idle(8);
    start(4'b1101, 7'b1111110, e0);
    push(EV_PERR, 16'h0, e0 + 4);
    idle(8);

    // Recapture ones (only ones seen so far), then finish the frame.
    cap(4'b1110, 7, 8, 1'b0, 16'h0);
    cap(4'b0111, 10, 8, 1'b0, 16'h0);
    cap(4'b1011, 11, 8, 1'b0, 16'h0);
    cap(4'b1101, 12, 8, 1'b1, 16'hABC7);
    check("hex_abc7", 64'(hex), 64'hABC7);

    // Timeout 100 cycles after a capture; next capture clears it.
    start(4'b1011, SEG[9], e0);
    push(EV_DIGIT, 16'h9, e0 + 4);
    push(EV_TSET, 16'h0, e0 + 104);
    idle(110);
    check("timeout_level", 64'(tout), 64'h1);
    start(4'b0111, SEG[0], e0);
    push(EV_DIGIT, 16'h0, e0 + 4);
    push(EV_TCLR, 16'h0, e0 + 4);
    idle(8);
    // The timeout dropped the hundreds seen bit, so hundreds completes it.
    cap(4'b1101, 5, 8, 1'b0, 16'h0);
    cap(4'b1110, 6, 8, 1'b0, 16'h0);
    cap(4'b1011, 8, 8, 1'b1, 16'h0856);

    // Two digits captured, reset in the middle of a third window.
    cap(4'b0111, 3, 8, 1'b0, 16'h0);
    cap(4'b1011, 4, 8, 1'b0, 16'h0);
    start(4'b1101, SEG[7], e0);
    idle(2);
    reset      = 1'b1;
    anode_bits = 4'hF;
    segs       = 7'h7F;
    idle(2);
    check("midreset_hex", 64'(hex), 64'h0);
    check("midreset_bcd", 64'(bcd), 64'h0);
    check("midreset_flags", 64'({dv, fv, pe, ae, tout}), 64'h0);
    reset = 1'b0;
    cap(4'b1101, 14, 8, 1'b0, 16'h0);
    cap(4'b1110, 15, 8, 1'b0, 16'h0);
    cap(4'b0111, 1, 8, 1'b0, 16'h0);
    cap(4'b1011, 2, 8, 1'b1, 16'h12EF);
    check("hex_12ef", 64'(hex), 64'h12EF);
    check("bcd_two", 64'(bcd), 64'h2);

    idle(10);
    check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
